// File: rtl/casas_fill_ctrl.sv
// casas_fill_ctrl
//   Sequencer for the 8-slot homes ("casas") register of the Frogger datapath.
//   It generates the clear, initial-load and variable-load strobes for the register.
//   When the frog arrives, it marks that home. When the row is full, it announces
//   level completion, then clears and reloads the row for the next level.
//   The homes register contents come back in on SC_CasasCtrl_casas_InBUS.
//
// Ports
//   SC_CasasCtrl_CLOCK_50            in   clock
//   SC_CasasCtrl_RESET_InHigh        in   asynchronous reset, active-high
//   SC_CasasCtrl_start_InLow         in   level start request (sampled in IDLE)
//   SC_CasasCtrl_abort_InLow         in   abort game: CLEAR, then IDLE
//   SC_CasasCtrl_arrive_InHigh       in   one-cycle pulse, frog reached the home row
//   SC_CasasCtrl_arriveIdx_InBUS     in   slot index of the arrival
//   SC_CasasCtrl_casas_InBUS         in   current homes register contents
//   SC_CasasCtrl_clear_OutLow        out  register clear strobe
//   SC_CasasCtrl_loadInicial_OutLow  out  register initial-load strobe
//   SC_CasasCtrl_dataInicial_OutBUS  out  initial pattern (constant INIT_PATTERN)
//   SC_CasasCtrl_loadVariado_OutLow  out  register variable-load strobe
//   SC_CasasCtrl_dataVariada_OutBUS  out  variable-load data (homes plus new slot)
//   SC_CasasCtrl_homed_OutHigh       out  pulse: arrival accepted
//   SC_CasasCtrl_occupied_OutHigh    out  pulse: arrival rejected
//   SC_CasasCtrl_levelDone_OutHigh   out  high for WIN_HOLD cycles after a full row
//   SC_CasasCtrl_level_OutBUS        out  completed-level counter (wraps)
//   SC_CasasCtrl_busy_OutHigh        out  high in every state except IDLE and PLAY
module casas_fill_ctrl #(
  parameter int unsigned          DATAWIDTH    = 8,
  parameter int unsigned          IDXWIDTH     = 3,
  parameter logic [DATAWIDTH-1:0] INIT_PATTERN = '0,
  parameter logic [DATAWIDTH-1:0] FULL_MASK    = '1,
  parameter int unsigned          WIN_HOLD     = 4
) (
  input  logic                 SC_CasasCtrl_CLOCK_50,
  input  logic                 SC_CasasCtrl_RESET_InHigh,
  input  logic                 SC_CasasCtrl_start_InLow,
  input  logic                 SC_CasasCtrl_abort_InLow,
  input  logic                 SC_CasasCtrl_arrive_InHigh,
  input  logic [IDXWIDTH-1:0]  SC_CasasCtrl_arriveIdx_InBUS,
  input  logic [DATAWIDTH-1:0] SC_CasasCtrl_casas_InBUS,
  output logic                 SC_CasasCtrl_clear_OutLow,
  output logic                 SC_CasasCtrl_loadInicial_OutLow,
  output logic [DATAWIDTH-1:0] SC_CasasCtrl_dataInicial_OutBUS,
  output logic                 SC_CasasCtrl_loadVariado_OutLow,
  output logic [DATAWIDTH-1:0] SC_CasasCtrl_dataVariada_OutBUS,
  output logic                 SC_CasasCtrl_homed_OutHigh,
  output logic                 SC_CasasCtrl_occupied_OutHigh,
  output logic                 SC_CasasCtrl_levelDone_OutHigh,
  output logic [3:0]           SC_CasasCtrl_level_OutBUS,
  output logic                 SC_CasasCtrl_busy_OutHigh
);

  localparam int unsigned HOLDW = (WIN_HOLD > 1) ? $clog2(WIN_HOLD) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    PLAY,
    WRITE,
    SETTLE,
    FULL
  } stateT;

  stateT              state;
  logic [HOLDW-1:0]   holdCnt;
  logic               abortPend;

  logic [DATAWIDTH-1:0] slotBit_c;
  logic                 idxInRange_c;
  logic                 arriveOk_c;
  logic                 rowFull_c;
  logic                 abortReq_c;

  // The initial pattern is a fixed constant, so it needs no register.
  assign SC_CasasCtrl_dataInicial_OutBUS = INIT_PATTERN;

  // An index beyond the register width shifts the bit out of range. That slot
  // then fails the mask check and is treated as occupied.
  assign slotBit_c    = DATAWIDTH'(1) << SC_CasasCtrl_arriveIdx_InBUS;
  assign idxInRange_c = (32'(SC_CasasCtrl_arriveIdx_InBUS) < DATAWIDTH);
  assign arriveOk_c   = idxInRange_c
                        && (|(slotBit_c & FULL_MASK))
                        && !(|(slotBit_c & SC_CasasCtrl_casas_InBUS));
  assign rowFull_c    = ((SC_CasasCtrl_casas_InBUS & FULL_MASK) == FULL_MASK);
  assign abortReq_c   = !SC_CasasCtrl_abort_InLow;

  // State plus registered outputs. Each output takes the value that belongs to
  // the state being entered, so it changes on the same edge as the state.
  always_ff @(posedge SC_CasasCtrl_CLOCK_50 or posedge SC_CasasCtrl_RESET_InHigh) begin
    if (SC_CasasCtrl_RESET_InHigh) begin
      state                           <= IDLE;
      holdCnt                         <= '0;
      abortPend                       <= 1'b0;
      SC_CasasCtrl_clear_OutLow       <= 1'b1;
      SC_CasasCtrl_loadInicial_OutLow <= 1'b1;
      SC_CasasCtrl_loadVariado_OutLow <= 1'b1;
      SC_CasasCtrl_dataVariada_OutBUS <= '0;
      SC_CasasCtrl_homed_OutHigh      <= 1'b0;
      SC_CasasCtrl_occupied_OutHigh   <= 1'b0;
      SC_CasasCtrl_levelDone_OutHigh  <= 1'b0;
      SC_CasasCtrl_level_OutBUS       <= 4'd0;
      SC_CasasCtrl_busy_OutHigh       <= 1'b0;
    end else begin
      // Strobes and pulses last one cycle unless the transition below re-asserts them.
      SC_CasasCtrl_clear_OutLow       <= 1'b1;
      SC_CasasCtrl_loadInicial_OutLow <= 1'b1;
      SC_CasasCtrl_loadVariado_OutLow <= 1'b1;
      SC_CasasCtrl_homed_OutHigh      <= 1'b0;
      SC_CasasCtrl_occupied_OutHigh   <= 1'b0;

      if (abortReq_c && (state != IDLE) && (state != CLEAR)) begin
        // Abort overrides any arrival and drops a pending write. The level count is kept.
        state                          <= CLEAR;
        abortPend                      <= 1'b1;
        holdCnt                        <= '0;
        SC_CasasCtrl_clear_OutLow      <= 1'b0;
        SC_CasasCtrl_levelDone_OutHigh <= 1'b0;
        SC_CasasCtrl_busy_OutHigh      <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (!SC_CasasCtrl_start_InLow) begin
              state                     <= CLEAR;
              abortPend                 <= 1'b0;
              SC_CasasCtrl_clear_OutLow <= 1'b0;
              SC_CasasCtrl_busy_OutHigh <= 1'b1;
            end
          end

          CLEAR: begin
            if (abortPend) begin
              state                     <= IDLE;
              abortPend                 <= 1'b0;
              SC_CasasCtrl_busy_OutHigh <= 1'b0;
            end else begin
              state                           <= LOAD;
              SC_CasasCtrl_loadInicial_OutLow <= 1'b0;
              SC_CasasCtrl_busy_OutHigh       <= 1'b1;
            end
          end

          LOAD: begin
            state                     <= PLAY;
            SC_CasasCtrl_busy_OutHigh <= 1'b0;
          end

          PLAY: begin
            if (SC_CasasCtrl_arrive_InHigh) begin
              if (arriveOk_c) begin
                // The register is stable in PLAY, so the write data can be built now.
                state                           <= WRITE;
                SC_CasasCtrl_loadVariado_OutLow <= 1'b0;
                SC_CasasCtrl_dataVariada_OutBUS <= SC_CasasCtrl_casas_InBUS | slotBit_c;
                SC_CasasCtrl_homed_OutHigh      <= 1'b1;
                SC_CasasCtrl_busy_OutHigh       <= 1'b1;
              end else begin
                SC_CasasCtrl_occupied_OutHigh   <= 1'b1;
              end
            end
          end

          WRITE: begin
            // The register captures the new data on this edge. It is visible in SETTLE.
            state <= SETTLE;
          end

          SETTLE: begin
            if (rowFull_c) begin
              state                          <= FULL;
              holdCnt                        <= HOLDW'(WIN_HOLD - 1);
              SC_CasasCtrl_level_OutBUS      <= SC_CasasCtrl_level_OutBUS + 4'd1;
              SC_CasasCtrl_levelDone_OutHigh <= 1'b1;
            end else begin
              state                          <= PLAY;
              SC_CasasCtrl_busy_OutHigh      <= 1'b0;
            end
          end

          FULL: begin
            if (holdCnt == '0) begin
              state                          <= CLEAR;
              SC_CasasCtrl_levelDone_OutHigh <= 1'b0;
              SC_CasasCtrl_clear_OutLow      <= 1'b0;
            end else begin
              holdCnt <= holdCnt - HOLDW'(1);
            end
          end

          default: begin
            state                          <= IDLE;
            abortPend                      <= 1'b0;
            SC_CasasCtrl_levelDone_OutHigh <= 1'b0;
            SC_CasasCtrl_busy_OutHigh      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_casas_fill_ctrl.sv
// Bench for casas_fill_ctrl, with a behavioural homes register driven by the DUT strobes.
module tb_casas_fill_ctrl;

  localparam logic [7:0] INIT = 8'h00;
  localparam logic [7:0] MASK = 8'hFF;

  logic       clk = 1'b0;
  logic       rst;
  logic       startN, abortN, arrive;
  logic [2:0] idx;
  logic [7:0] casasReg;

  logic       clrN, liN, lvN, homed, occ, done, busy;
  logic [7:0] dataIni, dataVar;
  logic [3:0] level;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         kind;   // 0 homed, 1 occupied, 2 level done
    logic [7:0] data;
  } evT;
  evT sb[$];
  evT ev;

  logic [7:0] expHomes;
  logic [3:0] expLevel;
  logic       prevDone = 1'b0;

  always #5 clk = ~clk;

  casas_fill_ctrl dut (
    .SC_CasasCtrl_CLOCK_50           (clk),
    .SC_CasasCtrl_RESET_InHigh       (rst),
    .SC_CasasCtrl_start_InLow        (startN),
    .SC_CasasCtrl_abort_InLow        (abortN),
    .SC_CasasCtrl_arrive_InHigh      (arrive),
    .SC_CasasCtrl_arriveIdx_InBUS    (idx),
    .SC_CasasCtrl_casas_InBUS        (casasReg),
    .SC_CasasCtrl_clear_OutLow       (clrN),
    .SC_CasasCtrl_loadInicial_OutLow (liN),
    .SC_CasasCtrl_dataInicial_OutBUS (dataIni),
    .SC_CasasCtrl_loadVariado_OutLow (lvN),
    .SC_CasasCtrl_dataVariada_OutBUS (dataVar),
    .SC_CasasCtrl_homed_OutHigh      (homed),
    .SC_CasasCtrl_occupied_OutHigh   (occ),
    .SC_CasasCtrl_levelDone_OutHigh  (done),
    .SC_CasasCtrl_level_OutBUS       (level),
    .SC_CasasCtrl_busy_OutHigh       (busy)
  );

  // Homes register as seen by the controller. Clear has the highest priority.
  always @(posedge clk or posedge rst) begin
    if (rst)       casasReg <= 8'h00;
    else if (!clrN) casasReg <= 8'h00;
    else if (!liN)  casasReg <= dataIni;
    else if (!lvN)  casasReg <= dataVar;
  end

  // Scoreboard monitor: each pulse from the DUT must match the next expected event.
  always @(negedge clk) begin
    tests++;
    if ($countones(~{clrN, liN, lvN}) > 1) begin
      fails++;
      $display("FAIL strobe_overlap: clr=%b li=%b lv=%b, at most one may be low", clrN, liN, lvN);
    end
    if (homed === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_homed: data=%h, no event expected", dataVar);
      end else begin
        ev = sb.pop_front();
        if (ev.kind !== 0 || dataVar !== ev.data) begin
          fails++;
          $display("FAIL homed_event: kind 0 data %h, expected kind %0d data %h", dataVar, ev.kind, ev.data);
        end
      end
      tests++;
      if (lvN !== 1'b0) begin
        fails++;
        $display("FAIL homed_strobe: loadVariado=%b, expected 0", lvN);
      end
    end
    if (occ === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_occupied: no event expected");
      end else begin
        ev = sb.pop_front();
        if (ev.kind !== 1) begin
          fails++;
          $display("FAIL occupied_event: kind 1, expected kind %0d", ev.kind);
        end
      end
    end
    if (done === 1'b1 && prevDone !== 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_levelDone: level=%0d", level);
      end else begin
        ev = sb.pop_front();
        if (ev.kind !== 2 || {4'h0, level} !== ev.data) begin
          fails++;
          $display("FAIL levelDone_event: kind 2 level %0d, expected kind %0d level %0d", level, ev.kind, ev.data);
        end
      end
    end
    prevDone = done;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a level from IDLE and check the clear and initial-load strobes. Ends in PLAY.
  task automatic start_level(input string name);
    startN = 1'b0;
    tick();
    startN = 1'b1;
    @(negedge clk);
    tests++;
    if ({clrN, liN, lvN, busy} !== 4'b0111) begin
      fails++;
      $display("FAIL %s_clear: clr/li/lv/busy=%b, expected 0111", name, {clrN, liN, lvN, busy});
    end
    tick();
    @(negedge clk);
    tests++;
    if ({clrN, liN, lvN, busy} !== 4'b1011) begin
      fails++;
      $display("FAIL %s_load: clr/li/lv/busy=%b, expected 1011", name, {clrN, liN, lvN, busy});
    end
    tick();
    @(negedge clk);
    tests++;
    if ({clrN, liN, lvN, busy} !== 4'b1110 || casasReg !== INIT) begin
      fails++;
      $display("FAIL %s_play: clr/li/lv/busy=%b casas=%h, expected 1110 casas %h",
               name, {clrN, liN, lvN, busy}, casasReg, INIT);
    end
    expHomes = INIT;
    tick();
  endtask

  // Arrival in PLAY. Accepted arrivals end in PLAY, or in FULL on a full row.
  task automatic do_arrive(input logic [2:0] i);
    logic [7:0] bitv;
    logic       accept;
    bitv   = 8'h01 << i;
    accept = ((bitv & MASK) != 8'h00) && ((expHomes & bitv) == 8'h00);
    if (accept) begin
      sb.push_back(evT'{kind: 0, data: expHomes | bitv});
      expHomes = expHomes | bitv;
      if ((expHomes & MASK) == MASK) begin
        expLevel = expLevel + 4'd1;
        sb.push_back(evT'{kind: 2, data: {4'h0, expLevel}});
      end
    end else begin
      sb.push_back(evT'{kind: 1, data: 8'h00});
    end
    arrive = 1'b1;
    idx    = i;
    tick();
    arrive = 1'b0;
    @(negedge clk);
    tests++;
    if (lvN !== !accept) begin
      fails++;
      $display("FAIL arrive_strobe idx %0d: loadVariado=%b, expected %b", i, lvN, !accept);
    end
    tick();
    if (accept) begin
      @(negedge clk);
      tests++;
      if ({lvN, busy} !== 2'b11 || casasReg !== expHomes) begin
        fails++;
        $display("FAIL settle idx %0d: lv/busy=%b casas=%h, expected 11 casas %h",
                 i, {lvN, busy}, casasReg, expHomes);
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; startN = 1'b1; abortN = 1'b1; arrive = 1'b0; idx = 3'd0;
    expHomes = 8'h00; expLevel = 4'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({clrN, liN, lvN, homed, occ, done, busy} !== 7'b1110000) begin
      fails++;
      $display("FAIL reset_ctrl: clr/li/lv/homed/occ/done/busy=%b, expected 1110000",
               {clrN, liN, lvN, homed, occ, done, busy});
    end
    tests++;
    if (level !== 4'd0 || dataVar !== 8'h00 || dataIni !== INIT) begin
      fails++;
      $display("FAIL reset_data: level=%0d dataVar=%h dataIni=%h, expected 0 00 %h", level, dataVar, dataIni, INIT);
    end
    tick();
  endtask

  task automatic test_single_home();
    do_arrive(3'd3);
  endtask

  task automatic test_occupied();
    do_arrive(3'd3);
    @(negedge clk);
    tests++;
    if ({lvN, busy} !== 2'b10 || casasReg !== 8'h08) begin
      fails++;
      $display("FAIL occupied_state: lv/busy=%b casas=%h, expected 10 casas 08", {lvN, busy}, casasReg);
    end
    tick();
  endtask

  task automatic test_fill_row();
    int doneCnt = 0;
    int clrAt = -1;
    int liAt = -1;
    logic busyPlay = 1'b1;
    for (int i = 0; i < 8; i++) do_arrive(3'(i));
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (done === 1'b1) doneCnt++;
      if (clrN === 1'b0 && clrAt < 0) clrAt = k;
      if (liN === 1'b0 && liAt < 0) liAt = k;
      if (k == 6) busyPlay = busy;
      tick();
    end
    expHomes = INIT;
    tests++;
    if (doneCnt != 4) begin
      fails++;
      $display("FAIL levelDone_width: %0d cycles, expected 4", doneCnt);
    end
    tests++;
    if (clrAt != 4 || liAt != 5) begin
      fails++;
      $display("FAIL next_level_strobes: clear at %0d load at %0d, expected 4 and 5", clrAt, liAt);
    end
    tests++;
    if (busyPlay !== 1'b0 || casasReg !== INIT || level !== 4'd1) begin
      fails++;
      $display("FAIL next_level_play: busy=%b casas=%h level=%0d, expected 0 %h 1", busyPlay, casasReg, INIT, level);
    end
  endtask

  task automatic test_abort_full();
    for (int i = 7; i >= 0; i--) do_arrive(3'(i));
    abortN = 1'b0;
    tick();
    abortN = 1'b1;
    @(negedge clk);
    tests++;
    if ({clrN, liN, lvN, done, busy} !== 5'b01101) begin
      fails++;
      $display("FAIL abort_clear: clr/li/lv/done/busy=%b, expected 01101", {clrN, liN, lvN, done, busy});
    end
    tick();
    @(negedge clk);
    tests++;
    if ({clrN, liN, busy} !== 3'b110 || level !== 4'd2) begin
      fails++;
      $display("FAIL abort_idle: clr/li/busy=%b level=%0d, expected 110 level 2", {clrN, liN, busy}, level);
    end
    repeat (2) tick();
    @(negedge clk);
    tests++;
    if ({clrN, liN, busy} !== 3'b110) begin
      fails++;
      $display("FAIL abort_stays_idle: clr/li/busy=%b, expected 110", {clrN, liN, busy});
    end
    tick();
  endtask

  task automatic test_dropped();
    // Arrival sampled in LOAD.
    startN = 1'b0;
    tick();
    startN = 1'b1;
    tick();
    arrive = 1'b1; idx = 3'd5;
    tick();
    arrive = 1'b0;
    expHomes = INIT;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tests++;
      if ({homed, occ, lvN, busy} !== 4'b0010) begin
        fails++;
        $display("FAIL drop_load %0d: homed/occ/lv/busy=%b, expected 0010", k, {homed, occ, lvN, busy});
      end
      tick();
    end
    // Arrival sampled in SETTLE.
    sb.push_back(evT'{kind: 0, data: expHomes | 8'h02});
    expHomes = expHomes | 8'h02;
    arrive = 1'b1; idx = 3'd1;
    tick();
    arrive = 1'b0;
    tick();
    arrive = 1'b1; idx = 3'd6;
    tick();
    arrive = 1'b0;
    @(negedge clk);
    tests++;
    if ({homed, occ, lvN} !== 3'b001) begin
      fails++;
      $display("FAIL drop_settle: homed/occ/lv=%b, expected 001", {homed, occ, lvN});
    end
    tick();
    tests++;
    if (casasReg !== expHomes) begin
      fails++;
      $display("FAIL drop_settle_casas: casas=%h, expected %h", casasReg, expHomes);
    end
    do_arrive(3'd6);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL pending_events: %0d left, expected 0", sb.size());
    end
    // Reset while a write is in progress.
    arrive = 1'b1; idx = 3'd0;
    tick();
    arrive = 1'b0;
    tests++;
    if (lvN !== 1'b0) begin
      fails++;
      $display("FAIL write_before_reset: loadVariado=%b, expected 0", lvN);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({clrN, liN, lvN, homed, busy} !== 5'b11100 || level !== 4'd0) begin
      fails++;
      $display("FAIL reset_mid_write: clr/li/lv/homed/busy=%b level=%0d, expected 11100 level 0",
               {clrN, liN, lvN, homed, busy}, level);
    end
    @(negedge clk);
    rst = 1'b0;
    expHomes = 8'h00;
    expLevel = 4'd0;
    tick();
    @(negedge clk);
    tests++;
    if ({clrN, liN, lvN, busy} !== 4'b1110) begin
      fails++;
      $display("FAIL after_reset_idle: clr/li/lv/busy=%b, expected 1110", {clrN, liN, lvN, busy});
    end
    tick();
  endtask

  // Sixteen rows filled in random order, which makes the level counter wrap to 0.
  task automatic test_level_wrap();
    int tries;
    start_level("wrap");
    for (int row = 0; row < 16; row++) begin
      tries = 0;
      while ((expHomes & MASK) != MASK && tries < 300) begin
        do_arrive(3'($urandom_range(0, 7)));
        tries++;
      end
      tests++;
      if ((expHomes & MASK) != MASK) begin
        fails++;
        $display("FAIL wrap_fill row %0d: homes=%h after %0d tries", row, expHomes, tries);
      end
      repeat (6) tick();
      expHomes = INIT;
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || casasReg !== INIT) begin
        fails++;
        $display("FAIL wrap_play row %0d: busy=%b casas=%h, expected 0 %h", row, busy, casasReg, INIT);
      end
      tick();
    end
    tests++;
    if (level !== 4'd0) begin
      fails++;
      $display("FAIL level_wrap: level=%0d, expected 0", level);
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL final_events: %0d left, expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    start_level("start");
    test_single_home();
    test_occupied();
    test_fill_row();
    test_abort_full();
    test_dropped();
    test_level_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
